// File: rtl/spi_flash_pkg.sv
// Shared states and byte constants for the SPI flash loader.
// FLASH_FAST_READ_EN selects the fast-read command and adds the DUMMY state.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] DUMMY_BYTE    = 8'hFF;
    localparam logic [7:0] IDLE_MOSI     = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CMD,
        S_ADDR,
`ifdef FLASH_FAST_READ_EN
        S_DUMMY,
`endif
        S_READ,
        S_CS_GAP
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_ACK,
        X_FIN,
        X_REL
    } xfer_state_e;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE   = CMD_FAST_READ;
    localparam state_e     AFTER_ADDR = S_DUMMY;
`else
    localparam logic [7:0] CMD_BYTE   = CMD_READ;
    localparam state_e     AFTER_ADDR = S_READ;
`endif

endpackage

// File: rtl/spi_byte_xfer.sv
// One byte through the SPI engine: raise request, wait wait_n low, wait wait_n high,
// then drop the request for one cycle. fin_o pulses as the request is released.
module spi_byte_xfer
    import spi_flash_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go_i,
    input  logic       is_write_i,
    input  logic [7:0] tx_i,
    output logic       fin_o,
    output logic [7:0] rx_o,
    output logic       eng_send_o,
    output logic       eng_recv_o,
    output logic [7:0] eng_din_o,
    input  logic [7:0] eng_dout_i,
    input  logic       eng_wait_n_i
);

    xfer_state_e state_q, state_d;
    logic        send_q, send_d;
    logic        recv_q, recv_d;
    logic [7:0]  din_q, din_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= X_IDLE;
            send_q  <= 1'b0;
            recv_q  <= 1'b0;
            din_q   <= IDLE_MOSI;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            recv_q  <= recv_d;
            din_q   <= din_d;
        end
    end

    // A new byte may start from REL, so the request is low for exactly that one cycle.
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        recv_d  = recv_q;
        din_d   = din_q;
        fin_o   = 1'b0;
        case (state_q)
            X_IDLE, X_REL: begin
                if (go_i) begin
                    state_d = X_ACK;
                    send_d  = is_write_i;
                    recv_d  = !is_write_i;
                    din_d   = is_write_i ? tx_i : IDLE_MOSI;
                end else begin
                    state_d = X_IDLE;
                end
            end
            X_ACK: if (!eng_wait_n_i) state_d = X_FIN;
            X_FIN: begin
                if (eng_wait_n_i) begin
                    state_d = X_REL;
                    send_d  = 1'b0;
                    recv_d  = 1'b0;
                    fin_o   = 1'b1;
                end
            end
            default: state_d = X_IDLE;
        endcase
    end

    assign rx_o       = eng_dout_i;
    assign eng_send_o = send_q;
    assign eng_recv_o = recv_q;
    assign eng_din_o  = din_q;

endmodule

// File: rtl/spi_flash_loader.sv
// Flash READ sequencer: frames cs_n, sends command and address, then streams len bytes
// to a valid/ready consumer. Define FLASH_FAST_READ_EN for 0x0B plus one dummy byte.
module spi_flash_loader
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 16,
    parameter int CS_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              cs_n,
    output logic              eng_send,
    output logic              eng_recv,
    output logic [7:0]        eng_din,
    input  logic [7:0]        eng_dout,
    input  logic              eng_wait_n,
    output state_e            dbg_state_o
);

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int IDX_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int GAP_W      = 4;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              pend_q, pend_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              go, is_write, accept;
    logic [7:0]        tx_byte, addr_byte;
    logic              xfer_fin;
    logic [7:0]        xfer_rx;

    assign addr_byte = 8'(addr_q >> (8 * (ADDR_BYTES - 1 - int'(idx_q))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            pend_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            pend_q     <= pend_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // pend_q marks a byte handed to the engine whose fin has not yet returned.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        pend_d     = pend_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        go         = 1'b0;
        is_write   = 1'b1;
        tx_byte    = IDLE_MOSI;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = addr;
                    rem_d  = len;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_CS_SETUP;
                        cs_n_d  = 1'b0;
                    end
                end
            end
            S_CS_SETUP: state_d = S_CMD;
            S_CMD: begin
                tx_byte = CMD_BYTE;
                if (!pend_q) begin
                    go     = 1'b1;
                    pend_d = 1'b1;
                end else if (xfer_fin) begin
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                tx_byte = addr_byte;
                if (!pend_q) begin
                    go     = 1'b1;
                    pend_d = 1'b1;
                end else if (xfer_fin) begin
                    pend_d = 1'b0;
                    if (idx_q == IDX_W'(ADDR_BYTES - 1)) state_d = AFTER_ADDR;
                    else idx_d = idx_q + 1'b1;
                end
            end
`ifdef FLASH_FAST_READ_EN
            S_DUMMY: begin
                tx_byte = DUMMY_BYTE;
                if (!pend_q) begin
                    go     = 1'b1;
                    pend_d = 1'b1;
                end else if (xfer_fin) begin
                    pend_d  = 1'b0;
                    state_d = S_READ;
                end
            end
`endif
            S_READ: begin
                is_write = 1'b0;
                accept   = rd_valid_q && rd_ready;
                if (accept) begin
                    rd_valid_d = 1'b0;
                    rem_d      = rem_q - 1'b1;
                end
                // Next read issues no earlier than the cycle the previous byte is taken.
                if (pend_q) begin
                    if (xfer_fin) begin
                        pend_d     = 1'b0;
                        rd_data_d  = xfer_rx;
                        rd_valid_d = 1'b1;
                    end
                end else if (accept && rem_q == LEN_W'(1)) begin
                    state_d = S_CS_GAP;
                    cs_n_d  = 1'b1;
                    gap_d   = GAP_W'(CS_GAP - 1);
                end else if (!rd_valid_q || accept) begin
                    go     = 1'b1;
                    pend_d = 1'b1;
                end
            end
            S_CS_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    spi_byte_xfer u_xfer (
        .clk          (clk),
        .rst          (rst),
        .go_i         (go),
        .is_write_i   (is_write),
        .tx_i         (tx_byte),
        .fin_o        (xfer_fin),
        .rx_o         (xfer_rx),
        .eng_send_o   (eng_send),
        .eng_recv_o   (eng_recv),
        .eng_din_o    (eng_din),
        .eng_dout_i   (eng_dout),
        .eng_wait_n_i (eng_wait_n)
    );

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign cs_n        = cs_n_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Scoreboard bench for spi_flash_loader with a reactive SPI byte-engine model.
// Build with +define+FLASH_FAST_READ_EN to exercise the fast-read variant.
module tb_spi_flash_loader;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 16;
    localparam int CS_GAP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              busy, done, rd_valid, rd_ready, cs_n;
    logic [7:0]        rd_data;
    logic              eng_send, eng_recv, eng_wait_n;
    logic [7:0]        eng_din, eng_dout;
    spi_flash_pkg::state_e dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int cs_low_cnt = 0;

    logic [8:0] exp_eng_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] eng_rx_q[$];

    always #5 clk = ~clk;

    spi_flash_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .addr        (addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .cs_n        (cs_n),
        .eng_send    (eng_send),
        .eng_recv    (eng_recv),
        .eng_din     (eng_din),
        .eng_dout    (eng_dout),
        .eng_wait_n  (eng_wait_n),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_hdr(input logic [23:0] a);
`ifdef FLASH_FAST_READ_EN
        exp_eng_q.push_back({1'b0, 8'h0B});
`else
        exp_eng_q.push_back({1'b0, 8'h03});
`endif
        exp_eng_q.push_back({1'b0, a[23:16]});
        exp_eng_q.push_back({1'b0, a[15:8]});
        exp_eng_q.push_back({1'b0, a[7:0]});
`ifdef FLASH_FAST_READ_EN
        exp_eng_q.push_back({1'b0, 8'hFF});
`endif
    endtask

    task automatic push_rd(input logic [7:0] b);
        exp_eng_q.push_back({1'b1, 8'h00});
        eng_rx_q.push_back(b);
        exp_rd_q.push_back(b);
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] l, input logic exp_busy);
        @(posedge clk); #1;
        start = 1'b1;
        addr  = a;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, exp_busy);
    endtask

    task automatic wait_done(input string name);
        int t0;
        int k;
        t0 = done_cnt;
        k  = 0;
        while (done_cnt == t0 && k < 3000) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_done_seen"}, (done_cnt != t0), 1);
    endtask

    task automatic check_one_done(input string name, input int t0);
        repeat (4) @(negedge clk);
        #1;
        check({name, "_done_count"}, done_cnt - t0, 1);
    endtask

    // Byte-engine model: ack a request, finish it a few cycles later, wait for release.
    initial begin
        int  e_st;
        int  e_cnt;
        logic e_recv;
        eng_wait_n = 1'b1;
        eng_dout   = 8'h00;
        e_st  = 0;
        e_cnt = 0;
        e_recv = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                e_st = 0;
                eng_wait_n = 1'b1;
            end else begin
                case (e_st)
                    0: if (eng_send || eng_recv) begin
                        e_recv = eng_recv;
                        eng_wait_n = 1'b0;
                        e_cnt = $urandom_range(0, 2);
                        e_st = 1;
                    end
                    1: if (e_cnt == 0) begin
                        if (e_recv) eng_dout = (eng_rx_q.size() > 0) ? eng_rx_q.pop_front() : 8'h00;
                        eng_wait_n = 1'b1;
                        e_st = 2;
                    end else begin
                        e_cnt--;
                    end
                    default: if (!eng_send && !eng_recv) e_st = 0;
                endcase
            end
        end
    end

    // Engine-side monitor: every new request is popped against the expected byte stream.
    initial begin
        logic       req_prev;
        logic [7:0] din_hold;
        logic [8:0] exp_v;
        req_prev = 1'b0;
        din_hold = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_prev = 1'b0;
            end else begin
                if (eng_send && eng_recv) check("send_recv_exclusive", 1, 0);
                if ((eng_send || eng_recv) && !req_prev) begin
                    req_cnt++;
                    check("cs_low_during_byte", cs_n, 0);
                    if (exp_eng_q.size() == 0) begin
                        check("unexpected_engine_req", {eng_recv, eng_din}, 9'h000);
                    end else begin
                        exp_v = exp_eng_q.pop_front();
                        check("engine_byte", {eng_recv, eng_recv ? 8'h00 : eng_din}, exp_v);
                    end
                    din_hold = eng_din;
                end else if (eng_send || eng_recv) begin
                    check("eng_din_stable", eng_din, din_hold);
                end
                req_prev = eng_send || eng_recv;
            end
        end
    end

    // Consumer-side monitor: accepted bytes against the scoreboard, plus hold under stall.
    initial begin
        logic       v_prev, r_prev;
        logic [7:0] d_prev;
        logic [7:0] exp_b;
        v_prev = 1'b0;
        r_prev = 1'b0;
        d_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                v_prev = 1'b0;
            end else begin
                if (v_prev && !r_prev) begin
                    check("rd_valid_hold", rd_valid, 1);
                    check("rd_data_hold", rd_data, d_prev);
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_rd_byte", rd_data, 8'h00);
                    end else begin
                        exp_b = exp_rd_q.pop_front();
                        check("rd_data", rd_data, exp_b);
                    end
                end
                v_prev = rd_valid;
                r_prev = rd_ready;
                d_prev = rd_data;
            end
        end
    end

    // done / chip-select monitor: done drops busy, cs_n stays high at least CS_GAP cycles.
    initial begin
        int   high_run;
        logic seen_rise;
        logic cs_prev;
        high_run  = 0;
        seen_rise = 1'b0;
        cs_prev   = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen_rise = 1'b0;
                high_run  = 0;
                cs_prev   = 1'b1;
            end else begin
                if (done) begin
                    done_cnt++;
                    check("busy_low_on_done", busy, 0);
                end
                if (cs_n) begin
                    if (!cs_prev) seen_rise = 1'b1;
                    high_run++;
                end else begin
                    cs_low_cnt++;
                    if (cs_prev && seen_rise) check("cs_gap_min", (high_run >= CS_GAP), 1);
                    high_run = 0;
                end
                cs_prev = cs_n;
            end
        end
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int rc;
        int lc;
        int k;
        rst      = 1'b1;
        start    = 1'b0;
        addr     = '0;
        len      = '0;
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_cs_n", cs_n, 1);
        check("rst_eng_send", eng_send, 0);
        check("rst_eng_recv", eng_recv, 0);
        check("rst_eng_din", eng_din, 8'hFF);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 3-byte read.
        push_hdr(24'h012345);
        push_rd(8'hA1);
        push_rd(8'hB2);
        push_rd(8'hC3);
        t0 = done_cnt;
        do_start(24'h012345, 16'd3, 1'b1);
        wait_done("basic");
        check_one_done("basic", t0);

        // Zero length: done one cycle after start, no chip select, no engine traffic.
        rc = req_cnt;
        lc = cs_low_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        addr  = 24'h777777;
        len   = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        @(negedge clk);
        check("len0_done_pulse", done, 0);
        repeat (5) @(negedge clk);
        #1;
        check("len0_no_req", req_cnt - rc, 0);
        check("len0_cs_high", cs_low_cnt - lc, 0);

        // Consumer stall after the first byte.
        rd_ready = 1'b0;
        push_hdr(24'h00ABCD);
        push_rd(8'h5C);
        push_rd(8'h6D);
        t0 = done_cnt;
        do_start(24'h00ABCD, 16'd2, 1'b1);
        k = 0;
        while (!rd_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("stall_first_valid", rd_valid, 1);
        check("stall_first_data", rd_data, 8'h5C);
        #1;
        rc = req_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("stall_no_new_recv", req_cnt - rc, 0);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_done("stall");
        check_one_done("stall", t0);

        // Reset during the second address byte, then a clean 1-byte read.
        push_hdr(24'h112233);
        push_rd(8'hEE);
        push_rd(8'hEF);
        do_start(24'h112233, 16'd2, 1'b1);
        k = 0;
        while (!(eng_send && eng_din == 8'h22) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_addr_byte2", (eng_send && eng_din == 8'h22), 1);
        rst = 1'b1;
        #1;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_eng_send", eng_send, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        exp_eng_q.delete();
        exp_rd_q.delete();
        eng_rx_q.delete();
        rst = 1'b0;
        push_hdr(24'h000010);
        push_rd(8'h5A);
        t0 = done_cnt;
        do_start(24'h000010, 16'd1, 1'b1);
        wait_done("after_rst");
        check_one_done("after_rst", t0);

        // Start while busy is ignored.
        push_hdr(24'h012345);
        push_rd(8'h11);
        push_rd(8'h22);
        t0 = done_cnt;
        do_start(24'h012345, 16'd2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        addr  = 24'hABCDEF;
        len   = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored_start");
        check_one_done("ignored_start", t0);

        // Back-to-back transactions exercise the chip-select gap.
        push_hdr(24'h000100);
        push_rd(8'h77);
        push_hdr(24'h000200);
        push_rd(8'h88);
        push_hdr(24'h000300);
        push_rd(8'h99);
        do_start(24'h000100, 16'd1, 1'b1);
        wait_done("b2b_0");
        do_start(24'h000200, 16'd1, 1'b1);
        wait_done("b2b_1");
        do_start(24'h000300, 16'd1, 1'b1);
        wait_done("b2b_2");
        repeat (4) @(negedge clk);

        check("exp_eng_drained", exp_eng_q.size(), 0);
        check("exp_rd_drained", exp_rd_q.size(), 0);
        check("eng_rx_drained", eng_rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_flash_loader.md
Name: spi_flash_loader

Overview:
- Sequencer sitting in front of the SPI byte engine (one byte per request/wait_n handshake).
- Issues a flash READ command with a 24-bit address, then pulls a programmable number of bytes.
- Presents each byte to a consumer, e.g. the cartridge ROM loader, with a valid/ready handshake.
- Owns flash chip select; the byte engine itself has no CS.

Parameters:
ADDR_W, 24, flash address width; must be a multiple of 8
LEN_W, 16, byte-count width
CS_GAP, 4, minimum clk cycles cs_n stays high between transactions; allowed range 1..15

Ports:
clk  in  1  system clock, shared with the byte engine
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
addr  in  ADDR_W  start address, latched on an accepted start
len  in  LEN_W  byte count, latched on an accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the transaction ends
rd_data  out  8  byte delivered to the consumer
rd_valid  out  1  rd_data is valid; held until accepted
rd_ready  in  1  consumer accepts when rd_valid && rd_ready
cs_n  out  1  flash chip select, active low
eng_send  out  1  byte engine write request (enviar_dato)
eng_recv  out  1  byte engine read request (recibir_dato)
eng_din  out  8  byte to transmit
eng_dout  in  8  byte received from the engine
eng_wait_n  in  1  engine ready/finished, active high

Behaviour:
- Reset values: busy=0, done=0, rd_valid=0, rd_data=0, cs_n=1, eng_send=0, eng_recv=0, eng_din=8'hFF. Reset in mid-transaction drops cs_n and all requests immediately.
- States: IDLE -> CS_SETUP (1 cycle, cs_n=0) -> CMD -> ADDR (ADDR_W/8 bytes, MSB first) -> [DUMMY] -> READ (repeated) -> CS_GAP -> IDLE.
- Byte handshake (each CMD/ADDR/DUMMY/READ byte):
  - REQ: assert eng_send (with eng_din) or eng_recv.
  - ACK: wait for eng_wait_n=0.
  - FIN: wait for eng_wait_n=1.
  - REL: deassert the request for exactly 1 cycle, then advance. This lets the engine clear its cycle flag.
- Never assert eng_send and eng_recv together.
- Hold eng_din stable from REQ until REL.
- CMD byte is 8'h03. Address bytes are addr[23:16], addr[15:8], addr[7:0].
- READ uses eng_recv. In REL, eng_dout is copied to rd_data and rd_valid is set.
  - The next eng_recv is not issued until rd_valid && rd_ready.
  - rd_valid clears on the acceptance cycle.
  - A remaining counter decrements per accepted byte; when it reaches 0, go to CS_GAP.
- CS_GAP: cs_n=1 for CS_GAP cycles. done pulses on the cycle the FSM returns to IDLE; busy drops in that same cycle.
- len=0: cs_n is never asserted and no engine requests are made. done pulses 1 cycle after start.
- start while busy: ignored, with no effect on the latched addr/len.
- len counts in LEN_W bits. Maximum transfer is 2^LEN_W-1 bytes.
- Address wrap beyond flash size is left to the flash; the block never increments addr.

Optional Feature:
FLASH_FAST_READ_EN:
- Defined: CMD byte is 8'h0B and one DUMMY byte (eng_send, 8'hFF) follows the address before READ.
- Undefined: CMD is 8'h03, the DUMMY state does not exist, and no dummy byte is sent.

Decomposition:
- Package spi_flash_pkg holds: the state enum, CMD_READ=8'h03, CMD_FAST_READ=8'h0B, DUMMY_BYTE=8'hFF, IDLE_MOSI=8'hFF.
- Sub-module spi_byte_xfer implements the REQ/ACK/FIN/REL handshake.
  - Inputs: go, is_write, tx byte.
  - Outputs: fin pulse, rx byte, and the eng_* signals.
- The top FSM only sequences bytes and counts.

Test Plan:
- addr=24'h012345, len=3, rd_ready=1, engine model returns A1,B2,C3 -> eng_din sequence 03,01,23,45, three eng_recv transfers, rd_data A1,B2,C3, cs_n low throughout, one done pulse.
- len=0 -> cs_n stays 1, no eng_send/eng_recv, done exactly 1 cycle after start.
- rd_ready held 0 for 20 cycles after the first byte -> rd_valid and rd_data held, no new eng_recv, resumes after ready.
- rst asserted during ADDR byte 2 -> same cycle cs_n=1, eng_send=0, busy=0; a following start with len=1 completes normally.
- start pulsed while busy with a different addr -> ignored; original transfer bytes unchanged.
- FLASH_FAST_READ_EN defined, len=1 -> eng_din 0B,01,23,45,FF then one read; back-to-back starts see cs_n high for ≥CS_GAP cycles.
